// File: rtl/rns_fwd_converter_pipe.sv
// -----------------------------------------------------------------------------
// rns_fwd_converter_pipe
//
// Two-stage pipelined binary-to-residue forward converter for the moduli set
// {2^N-1, 2^N, 2^N+1}. A beat either encodes a 3N-bit binary word X into its
// three residues, or injects one of four programmable N-bit marker codes on
// all three residue channels.
//
// Stage 1 splits X into N-bit chunks {x2,x1,x0} and registers the chunk sums
// x0+x1+x2 and x0-x1+x2. Stage 2 reduces those sums modulo 2^N-1 and 2^N+1
// and registers the outputs. Full valid/ready backpressure; one beat per cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     [3N-1:0] binary operand X
//   in_pass     1 = encode in_data, 0 = inject marker selected by in_sel
//   in_sel      [1:0] marker select (ignored when in_pass = 1)
//   in_valid    input beat valid
//   in_ready    converter can accept a beat (combinational from out_ready)
//   out_r1      [N-1:0] X mod (2^N-1)
//   out_r2      [N-1:0] X mod 2^N
//   out_r3      [N:0]   X mod (2^N+1)
//   out_marker  current output beat is a marker
//   out_valid   output beat valid
//   out_ready   downstream accepts the beat
// -----------------------------------------------------------------------------
module rns_fwd_converter_pipe #(
    parameter int N   = 3,
    parameter int MK0 = 5,
    parameter int MK1 = 4,
    parameter int MK2 = 3,
    parameter int MK3 = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3*N-1:0] in_data,
    input  logic           in_pass,
    input  logic [1:0]     in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   out_r1,
    output logic [N-1:0]   out_r2,
    output logic [N:0]     out_r3,
    output logic           out_marker,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int M3 = (1 << N) + 1;

    // Chunks of the incoming operand, x0 being the least significant.
    logic [N-1:0] x0, x1, x2;
    assign x0 = in_data[N-1:0];
    assign x1 = in_data[2*N-1:N];
    assign x2 = in_data[3*N-1:2*N];

    // Stage 1 state.
    logic                s1_valid_q, s1_valid_d;
    logic [N+1:0]        s1_q, s1_d;      // x0+x1+x2, at most 3*(2^N-1)
    logic signed [N+1:0] d3_q, d3_d;      // x0-x1+x2, in -(2^N-1)..2^(N+1)-2
    logic [N-1:0]        x0_q, x0_d;
    logic                pass_q, pass_d;
    logic [1:0]          sel_q, sel_d;

    // Stage 2 (output) state.
    logic         out_valid_q, out_valid_d;
    logic         out_marker_q, out_marker_d;
    logic [N-1:0] out_r1_q, out_r1_d;
    logic [N-1:0] out_r2_q, out_r2_d;
    logic [N:0]   out_r3_q, out_r3_d;

    // Pipeline advance: a stage may load when it is empty or its content moves on.
    logic adv1, adv2;
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // -------------------------------------------------------------------------
    // Stage 1: chunk sums
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first, so no path through the
        // block leaves it unassigned and no latch is inferred.
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        d3_d       = d3_q;
        x0_d       = x0_q;
        pass_d     = pass_q;
        sel_d      = sel_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d   = {2'b00, x0} + {2'b00, x1} + {2'b00, x2};
                d3_d   = $signed({2'b00, x0}) - $signed({2'b00, x1})
                       + $signed({2'b00, x2});
                x0_d   = x0;
                pass_d = in_pass;
                sel_d  = in_sel;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: modular reduction
    // -------------------------------------------------------------------------
    // mod 2^N-1: 2^N == 1, so the bits above N are added back in (end-around
    // carry). Two folds suffice: after the first the value is at most 2^N+2,
    // so the second fold cannot carry out again.
    logic [N:0]   fold1;
    logic [N-1:0] fold2;
    logic [N-1:0] r1_enc;
    assign fold1  = {1'b0, s1_q[N-1:0]} + (N+1)'(s1_q[N+1:N]);
    assign fold2  = fold1[N-1:0] + N'(fold1[N]);
    // All-ones is the second representation of zero in this modulus.
    assign r1_enc = (fold2 == '1) ? '0 : fold2;

    // mod 2^N+1: d3 lies within one modulus on either side of the legal range,
    // so a single add or subtract of the modulus folds it into 0..2^N.
    int         d3_i, r3_i;
    logic [N:0] r3_enc;
    always_comb begin
        d3_i = int'(d3_q);
        if (d3_i < 0)
            r3_i = d3_i + M3;
        else if (d3_i >= M3)
            r3_i = d3_i - M3;
        else
            r3_i = d3_i;
        r3_enc = (N+1)'(r3_i);
    end

    logic [N-1:0] mk_code;
    always_comb begin
        case (sel_q)
            2'd0:    mk_code = N'(MK0);
            2'd1:    mk_code = N'(MK1);
            2'd2:    mk_code = N'(MK2);
            default: mk_code = N'(MK3);
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_marker_d = out_marker_q;
        out_r1_d     = out_r1_q;
        out_r2_d     = out_r2_q;
        out_r3_d     = out_r3_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (pass_q) begin
                    out_r1_d     = r1_enc;
                    out_r2_d     = x0_q;
                    out_r3_d     = r3_enc;
                    out_marker_d = 1'b0;
                end else begin
                    out_r1_d     = mk_code;
                    out_r2_d     = mk_code;
                    out_r3_d     = {1'b0, mk_code};
                    out_marker_d = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            d3_q         <= '0;
            x0_q         <= '0;
            pass_q       <= 1'b0;
            sel_q        <= '0;
            out_valid_q  <= 1'b0;
            out_marker_q <= 1'b0;
            out_r1_q     <= '0;
            out_r2_q     <= '0;
            out_r3_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the value
            // from before this edge, independent of statement order.
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            d3_q         <= d3_d;
            x0_q         <= x0_d;
            pass_q       <= pass_d;
            sel_q        <= sel_d;
            out_valid_q  <= out_valid_d;
            out_marker_q <= out_marker_d;
            out_r1_q     <= out_r1_d;
            out_r2_q     <= out_r2_d;
            out_r3_q     <= out_r3_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_marker = out_marker_q;
    assign out_r1     = out_r1_q;
    assign out_r2     = out_r2_q;
    assign out_r3     = out_r3_q;

endmodule
